// File: rtl/frame_load_feeder_if.sv
// Word-in / beat-out bundle between the frame feeder, its producer and the 2-bit beat counter.
// The slave view belongs to the feeder; the master view belongs to whatever drives it.
interface frame_load_feeder_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DATA_W-1:0]   in_data;
    logic                  load_in_sync;
    logic [1:0]            count;
    logic [DATA_W-1:0]     ser_data;
    logic                  ser_valid;
    logic [LVL_W-1:0]      fifo_level;
    logic                  count_err;

    modport slave (
        input  in_valid, in_data, count,
        output in_ready, load_in_sync, ser_data, ser_valid, fifo_level, count_err
    );

    modport master (
        output in_valid, in_data, count,
        input  in_ready, load_in_sync, ser_data, ser_valid, fifo_level, count_err
    );
endinterface

// File: rtl/frame_load_feeder.sv
// Buffers 4-slice words and streams them as back-to-back 4-beat frames, pulsing
// load_in_sync to restart the external beat counter and using its count to pick each slice.
module frame_load_feeder #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_load_feeder_if.slave   bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WORD_W = 4 * DATA_W;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [WORD_W-1:0]   frame_q, frame_d;
    logic                err_q, err_d;

    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;

    logic                empty;
    logic                full;
    logic                push;
    logic                load;

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        push     = bus.in_valid & ~full;
        // A new frame starts when idle, or on the last beat of the current one.
        load     = ~empty & ((state_q == S_IDLE) | (phase_q == 2'd3));

        state_d  = state_q;
        phase_d  = phase_q;
        frame_d  = frame_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (load) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, load})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (load) begin
            state_d = S_ACTIVE;
            phase_d = 2'd0;
            frame_d = mem_q[rd_ptr_q];
        end else if (state_q == S_ACTIVE) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
                state_d = S_IDLE;
            end
        end

        if ((state_q == S_ACTIVE) && (bus.count != phase_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= 2'd0;
            frame_q  <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready     = ~full;
    assign bus.load_in_sync = load;
    assign bus.ser_valid    = (state_q == S_ACTIVE);
    assign bus.ser_data     = (state_q == S_ACTIVE) ? frame_q[32'(bus.count) * DATA_W +: DATA_W] : '0;
    assign bus.fifo_level   = level_q;
    assign bus.count_err    = err_q;
endmodule

// File: tb/tb_frame_load_feeder.sv
// Self-checking bench for frame_load_feeder with a behavioural beat counter and a slice scoreboard.
module tb_frame_load_feeder;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_load_feeder_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus();

    frame_load_feeder #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] expQ [$];
    bit   sbEnable = 1'b1;
    logic forceEn  = 1'b0;
    logic [1:0] forceVal = 2'd0;
    logic [1:0] cntQ;

    // Stand-in for the external 2-bit counter: restarts at 0 the cycle after a load.
    always @(posedge clk) begin
        if (rst || bus.load_in_sync) cntQ <= 2'd0;
        else                         cntQ <= cntQ + 2'd1;
    end
    assign bus.count = forceEn ? forceVal : cntQ;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data);
        bus.in_valid = valid;
        bus.in_data  = data;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'h0);
        rst = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic drainAll(input string tag);
        bit done = 1'b0;
        applyStimulus(1'b0, 32'h0);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !bus.ser_valid) done = 1'b1;
        end
        checkOutput(tag, done, 1);
        nextCycle();
    endtask

    // Record accepted words as expected slices; compare every valid beat mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
        end else if (sbEnable) begin
            if (bus.in_valid && bus.in_ready) begin
                for (int k = 0; k < 4; k++) expQ.push_back(bus.in_data[k*DATA_W +: DATA_W]);
            end
            if (bus.ser_valid) begin
                if (expQ.size() == 0) checkOutput("ser_extra", bus.ser_valid, 0);
                else                  checkOutput("ser_data", bus.ser_data, expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // T1: reset state
        doReset();
        @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_load", bus.load_in_sync, 0);
        checkOutput("rst_ser_valid", bus.ser_valid, 0);
        checkOutput("rst_ser_data", bus.ser_data, 0);
        checkOutput("rst_level", bus.fifo_level, 0);
        checkOutput("rst_count_err", bus.count_err, 0);
        nextCycle();

        // T2: single word, load in cycle 1, beats in cycles 2-5
        for (int c = 0; c < 8; c++) begin
            if (c == 0) applyStimulus(1'b1, 32'h44332211);
            else        applyStimulus(1'b0, 32'h0);
            @(negedge clk);
            checkOutput("t2_load", bus.load_in_sync, (c == 1));
            checkOutput("t2_valid", bus.ser_valid, (c >= 2 && c <= 5));
            if (c == 1) checkOutput("t2_level", bus.fifo_level, 1);
            if (c == 2) checkOutput("t2_slice0", bus.ser_data, 8'h11);
            if (c == 5) checkOutput("t2_slice3", bus.ser_data, 8'h44);
            if (c == 6) checkOutput("t2_idle_data", bus.ser_data, 0);
            nextCycle();
        end
        checkOutput("t2_sb_empty", expQ.size(), 0);

        // T3: three words, seamless 12-beat stream
        for (int c = 0; c < 15; c++) begin
            if (c < 3) applyStimulus(1'b1, $urandom);
            else       applyStimulus(1'b0, 32'h0);
            @(negedge clk);
            checkOutput("t3_load", bus.load_in_sync, (c == 1 || c == 5 || c == 9));
            checkOutput("t3_valid", bus.ser_valid, (c >= 2 && c <= 13));
            nextCycle();
        end
        checkOutput("t3_sb_empty", expQ.size(), 0);
        checkOutput("t3_count_err", bus.count_err, 0);

        // T4: continuous offer until full
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, $urandom);
            @(negedge clk);
            checkOutput("t4_in_ready", bus.in_ready, (c != 5));
            if (c == 5) checkOutput("t4_level_full", bus.fifo_level, 4);
            nextCycle();
        end
        drainAll("t4_drain");
        checkOutput("t4_level_empty", bus.fifo_level, 0);
        checkOutput("t4_count_err", bus.count_err, 0);

        // T5: counter disagrees during the phase-0 beat
        doReset();
        sbEnable = 1'b0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus((c == 0), 32'hA1B2C3D4);
            forceEn  = (c == 2);
            forceVal = 2'd2;
            @(negedge clk);
            checkOutput("t5_count_err", bus.count_err, (c >= 3));
            nextCycle();
        end
        forceEn = 1'b0;
        doReset();
        sbEnable = 1'b1;
        @(negedge clk);
        checkOutput("t5_err_cleared", bus.count_err, 0);
        nextCycle();

        // T6: reset in cycle 3 of a three-word burst
        for (int c = 0; c < 4; c++) begin
            if (c < 3) applyStimulus(1'b1, $urandom);
            else       applyStimulus(1'b0, 32'h0);
            rst = (c == 3);
            @(negedge clk);
            nextCycle();
        end
        rst = 1'b0;
        for (int c = 4; c < 12; c++) begin
            @(negedge clk);
            if (c == 4) checkOutput("t6_level", bus.fifo_level, 0);
            checkOutput("t6_valid", bus.ser_valid, 0);
            checkOutput("t6_load", bus.load_in_sync, 0);
            nextCycle();
        end
        applyStimulus(1'b1, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("t6_new_load_pre", bus.load_in_sync, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t6_new_load", bus.load_in_sync, 1);
        nextCycle();
        drainAll("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
